exception_unit: RTL and testbench

//  Consumer side of the control unit's exception outputs. Takes the ID-stage invalid-opcode flag and
//  the EX-stage overflow flag, records EPC/Cause, and sequences the pipeline flush and PC redirect to
//  the handler. On ERET it redirects back to EPC. Sits beside the PC/IF logic and the hazard unit.

---
 rtl/exception_unit.sv | 121 ++++++++++++
 tb/tb_exception_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/exception_unit.sv
// Exception sequencer: records EPC/Cause for ID invalid-opcode and EX overflow
// faults, drives the flush/redirect pulse to the handler vector, and redirects
// back to EPC on ERET. Exceptions arriving while the handler is active or while
// the entry redirect is in flight are counted in a saturating drop counter.
module exception_unit #(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] HANDLER_ADDR = 32'h8000_0180,
    parameter int              CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_invalid,
    input  logic             ex_overflow,
    input  logic [PC_W-1:0]  id_pc,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic             eret,
    output logic             pc_redirect,
    output logic [PC_W-1:0]  redirect_addr,
    output logic             flush_if,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             exl,
    output logic [PC_W-1:0]  epc,
    output logic [31:0]      cause,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTER   = 2'd1,
        HANDLER = 2'd2,
        RETURN  = 2'd3
    } state_t;

    localparam logic [4:0] EXC_OV = 5'd12;
    localparam logic [4:0] EXC_RI = 5'd10;

    state_t state;
    logic   exc;

    assign exc = ex_overflow | id_invalid;

    // Saturating increment: the counter sticks at all-ones rather than wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // ExcCode sits in bits [6:2]; every other Cause bit reads as zero
    function automatic logic [31:0] cause_word(input logic [4:0] code);
        return {25'd0, code, 2'b00};
    endfunction

    // Exception FSM with all outputs registered alongside the state transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pc_redirect   <= 1'b0;
            redirect_addr <= '0;
            flush_if      <= 1'b0;
            flush_id      <= 1'b0;
            flush_ex      <= 1'b0;
            exl           <= 1'b0;
            epc           <= '0;
            cause         <= '0;
            drop_cnt      <= '0;
        end else begin
            pc_redirect   <= 1'b0;
            redirect_addr <= '0;
            flush_if      <= 1'b0;
            flush_id      <= 1'b0;
            flush_ex      <= 1'b0;
            case (state)
                // RETURN behaves like IDLE so an exception right after ERET
                // enters the handler again with no idle gap
                IDLE, RETURN: begin
                    state <= IDLE;
                    exl   <= 1'b0;
                    if (exc) begin
                        state         <= ENTER;
                        pc_redirect   <= 1'b1;
                        redirect_addr <= HANDLER_ADDR;
                        flush_if      <= 1'b1;
                        flush_id      <= 1'b1;
                        flush_ex      <= ex_overflow;
                        exl           <= 1'b1;
                        // Overflow is the older instruction, so it wins
                        if (ex_overflow) begin
                            epc   <= ex_pc;
                            cause <= cause_word(EXC_OV);
                        end else begin
                            epc   <= id_pc;
                            cause <= cause_word(EXC_RI);
                        end
                    end
                end
                // Inputs seen here belong to squashed instructions
                ENTER: begin
                    state <= HANDLER;
                    exl   <= 1'b1;
                    if (exc) drop_cnt <= sat_inc(drop_cnt);
                end
                HANDLER: begin
                    exl <= 1'b1;
                    if (exc) drop_cnt <= sat_inc(drop_cnt);
                    if (eret) begin
                        state         <= RETURN;
                        pc_redirect   <= 1'b1;
                        redirect_addr <= epc;
                        flush_if      <= 1'b1;
                        exl           <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    exl   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_unit.sv
// Scoreboard bench for exception_unit: a behavioural model predicts the
// registered outputs for each driven cycle and queues them; the entry is
// popped and compared once the DUT has clocked.
module tb_exception_unit;

    localparam logic [31:0] HVEC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_invalid = 1'b0;
    logic        ex_overflow = 1'b0;
    logic [31:0] id_pc = '0;
    logic [31:0] ex_pc = '0;
    logic        eret = 1'b0;
    logic        pc_redirect;
    logic [31:0] redirect_addr;
    logic        flush_if, flush_id, flush_ex, exl;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [7:0]  drop_cnt;

    exception_unit dut (
        .clk(clk), .rst(rst), .id_invalid(id_invalid), .ex_overflow(ex_overflow),
        .id_pc(id_pc), .ex_pc(ex_pc), .eret(eret), .pc_redirect(pc_redirect),
        .redirect_addr(redirect_addr), .flush_if(flush_if), .flush_id(flush_id),
        .flush_ex(flush_ex), .exl(exl), .epc(epc), .cause(cause), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        redirect;
        logic [31:0] addr;
        logic        fif, fid, fex, exl;
        logic [31:0] epc;
        logic [31:0] cause;
        logic [7:0]  drop;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_err = 0;

    // model state: 0 idle, 1 enter, 2 handler, 3 return
    int          ms = 0;
    logic [31:0] m_epc = '0;
    logic [4:0]  m_code = '0;
    logic [7:0]  m_drop = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ms = 0; m_epc = '0; m_code = '0; m_drop = '0;
        q.delete();
    endtask

    // Advance the model one cycle for the current inputs and queue its outputs
    task automatic predict(input string tag);
        exp_t e;
        logic ex;
        ex = ex_overflow | id_invalid;
        case (ms)
            0, 3: begin
                if (ex_overflow) begin ms = 1; m_epc = ex_pc; m_code = 5'd12; end
                else if (id_invalid) begin ms = 1; m_epc = id_pc; m_code = 5'd10; end
                else ms = 0;
            end
            1: begin
                if (ex && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
                ms = 2;
            end
            default: begin
                if (ex && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
                if (eret) ms = 3;
            end
        endcase
        e.tag      = tag;
        e.redirect = (ms == 1) || (ms == 3);
        e.addr     = (ms == 1) ? HVEC : ((ms == 3) ? m_epc : 32'h0);
        e.fif      = (ms == 1) || (ms == 3);
        e.fid      = (ms == 1);
        e.fex      = (ms == 1) && (m_code == 5'd12);
        e.exl      = (ms == 1) || (ms == 2);
        e.epc      = m_epc;
        e.cause    = {25'd0, m_code, 2'b00};
        e.drop     = m_drop;
        q.push_back(e);
    endtask

    task automatic compare_head();
        exp_t e;
        if (q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
            return;
        end
        e = q.pop_front();
        chk({e.tag, ".redirect"}, {31'd0, pc_redirect}, {31'd0, e.redirect});
        chk({e.tag, ".addr"}, redirect_addr, e.addr);
        chk({e.tag, ".flush_if"}, {31'd0, flush_if}, {31'd0, e.fif});
        chk({e.tag, ".flush_id"}, {31'd0, flush_id}, {31'd0, e.fid});
        chk({e.tag, ".flush_ex"}, {31'd0, flush_ex}, {31'd0, e.fex});
        chk({e.tag, ".exl"}, {31'd0, exl}, {31'd0, e.exl});
        chk({e.tag, ".epc"}, epc, e.epc);
        chk({e.tag, ".cause"}, cause, e.cause);
        chk({e.tag, ".drop"}, {24'd0, drop_cnt}, {24'd0, e.drop});
    endtask

    task automatic step(input string tag, input logic ov, input logic inv,
                        input logic [31:0] xpc, input logic [31:0] ipc, input logic er);
        ex_overflow = ov; id_invalid = inv; ex_pc = xpc; id_pc = ipc; eret = er;
        predict(tag);
        @(posedge clk);
        #1;
        compare_head();
        ex_overflow = 1'b0; id_invalid = 1'b0; eret = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".redirect"}, {31'd0, pc_redirect}, 32'd0);
        chk({tag, ".addr"}, redirect_addr, 32'd0);
        chk({tag, ".flush"}, {29'd0, flush_if, flush_id, flush_ex}, 32'd0);
        chk({tag, ".exl"}, {31'd0, exl}, 32'd0);
        chk({tag, ".epc"}, epc, 32'd0);
        chk({tag, ".cause"}, cause, 32'd0);
        chk({tag, ".drop"}, {24'd0, drop_cnt}, 32'd0);
    endtask

    initial begin
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        step("idle", 0, 0, 32'h10, 32'h14, 0);

        // Overflow entry and return
        step("ovf_enter", 1, 0, 32'h40, 32'h44, 0);
        step("ovf_handler", 0, 0, 32'h0, 32'h0, 0);
        step("ovf_handler2", 0, 0, 32'h0, 32'h0, 0);
        step("ovf_eret", 0, 0, 32'h0, 32'h0, 1);
        step("ovf_idle", 0, 0, 32'h0, 32'h0, 0);

        // Invalid opcode only
        step("inv_enter", 0, 1, 32'h90, 32'h44, 0);
        step("inv_handler", 0, 0, 32'h0, 32'h0, 0);
        step("inv_eret", 0, 0, 32'h0, 32'h0, 1);
        step("inv_idle", 0, 0, 32'h0, 32'h0, 0);

        // Simultaneous: overflow wins
        step("sim_enter", 1, 1, 32'h50, 32'h54, 0);
        step("sim_handler", 0, 0, 32'h0, 32'h0, 0);
        step("nested_drop", 0, 1, 32'h0, 32'h99, 0);
        step("eret_and_exc", 1, 0, 32'h77, 32'h0, 1);
        // Back-to-back: overflow during RETURN is taken
        step("b2b_enter", 1, 0, 32'h60, 32'h64, 0);
        step("enter_drop", 0, 1, 32'h0, 32'h68, 0);
        for (int i = 0; i < 300; i++) step("sat", 1, 0, 32'h1000 + i, 32'h0, 0);
        step("sat_eret", 0, 0, 32'h0, 32'h0, 1);
        step("sat_idle", 0, 0, 32'h0, 32'h0, 0);

        // ERET while idle is ignored
        step("idle_eret", 0, 0, 32'h0, 32'h0, 1);
        step("idle_after", 0, 0, 32'h0, 32'h0, 0);

        // Asynchronous reset in the middle of ENTER
        step("rst_enter", 1, 0, 32'h70, 32'h74, 0);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step("post_rst", 0, 0, 32'h0, 32'h0, 0);
        chk_all_zero("post_rst_zero");
        step("post_rst_enter", 0, 1, 32'h0, 32'hA4, 0);

        if (q.size() != 0) chk("queue_leftover", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
